// File: rtl/mctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, datapath selects.
// Used by mctrl_decode and multicycle_ctrl.
package mctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EX   = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    localparam logic [5:0] OP_AND  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b001010;
    localparam logic [5:0] OP_SW   = 6'b001011;
    localparam logic [5:0] OP_BEQ  = 6'b000101;
    localparam logic [5:0] OP_BNE  = 6'b000110;
    localparam logic [5:0] OP_BLT  = 6'b000111;
    localparam logic [5:0] OP_J    = 6'b001100;
    localparam logic [5:0] OP_CALL = 6'b001101;
    localparam logic [5:0] OP_RET  = 6'b001110;
    localparam logic [5:0] OP_NOP  = 6'b111110;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;
    localparam logic [1:0] PC_RET    = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC1 = 2'b10;

    // One-hot instruction class; all-zero means the opcode is undefined.
    typedef struct packed {
        logic r_type;
        logic i_type;
        logic load;
        logic store;
        logic beq;
        logic bne;
        logic blt;
        logic jump;
        logic call;
        logic ret;
        logic nop;
        logic halt;
    } iclass_t;

    function automatic logic branch_taken(iclass_t c, logic zero, logic neg);
        return (c.beq && zero) || (c.bne && !zero) || (c.blt && neg);
    endfunction

endpackage

// File: rtl/mctrl_decode.sv
// Opcode decoder: maps the instruction opcode onto a one-hot class plus an illegal flag.
module mctrl_decode
    import mctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    output iclass_t        iclass,
    output logic           illegal
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        iclass  = '0;
        illegal = 1'b0;
        case (opcode)
            OPW'(OP_AND):  iclass.r_type = 1'b1;
            OPW'(OP_ADDI): iclass.i_type = 1'b1;
            OPW'(OP_LW):   iclass.load   = 1'b1;
            OPW'(OP_SW):   iclass.store  = 1'b1;
            OPW'(OP_BEQ):  iclass.beq    = 1'b1;
            OPW'(OP_BNE):  iclass.bne    = 1'b1;
            OPW'(OP_BLT):  iclass.blt    = 1'b1;
            OPW'(OP_J):    iclass.jump   = 1'b1;
            OPW'(OP_CALL): iclass.call   = 1'b1;
            OPW'(OP_RET):  iclass.ret    = 1'b1;
            OPW'(OP_NOP):  iclass.nop    = 1'b1;
            OPW'(OP_HALT): iclass.halt   = 1'b1;
            default:       illegal       = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: state register plus combinational control decode, and a retired-instruction counter.
// Define MCTRL_MEM_HANDSHAKE_EN to make IF and MEM wait for mem_ready.
module multicycle_ctrl
    import mctrl_pkg::*;
#(
    parameter int OPW   = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   opcode,
    input  logic             zero,
    input  logic             neg,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             pc_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [1:0]       pc_src,
    output logic             alu_src,
    output logic             ext_src,
    output logic             reg_des,
    output logic             link,
    output logic [1:0]       wb_data,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t  cur, nxt;
    iclass_t ic;
    logic    dec_illegal;
    logic    mem_go;
    logic    retire;

    mctrl_decode #(.OPW(OPW)) u_decode (
        .opcode  (opcode),
        .iclass  (ic),
        .illegal (dec_illegal)
    );

`ifdef MCTRL_MEM_HANDSHAKE_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_go = 1'b1;
`endif

    always_comb begin
        nxt     = cur;
        pc_we   = 1'b0;
        ir_we   = 1'b0;
        reg_we  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        pc_src  = PC_INC;
        alu_src = 1'b0;
        ext_src = 1'b0;
        reg_des = 1'b0;
        link    = 1'b0;
        wb_data = WB_ALU;
        illegal = 1'b0;
        case (cur)
            S_IF: begin
                mem_rd = 1'b1;
                if (mem_go) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    nxt   = S_ID;
                end
            end
            S_ID: begin
                if (ic.jump) begin
                    pc_we  = 1'b1;
                    pc_src = PC_JUMP;
                    nxt    = S_IF;
                end else if (ic.call) begin
                    pc_we   = 1'b1;
                    pc_src  = PC_JUMP;
                    reg_we  = 1'b1;
                    link    = 1'b1;
                    wb_data = WB_PC1;
                    nxt     = S_IF;
                end else if (ic.ret) begin
                    pc_we  = 1'b1;
                    pc_src = PC_RET;
                    nxt    = S_IF;
                end else if (ic.halt) begin
                    nxt = S_HALT;
                end else if (ic.r_type || ic.i_type || ic.load || ic.store ||
                             ic.beq || ic.bne || ic.blt) begin
                    nxt = S_EX;
                end else if (ic.nop) begin
                    nxt = S_IF;
                end else begin
                    // Undefined opcodes retire as a NOP after flagging.
                    illegal = dec_illegal;
                    nxt     = S_IF;
                end
            end
            S_EX: begin
                alu_src = ic.i_type || ic.load || ic.store;
                ext_src = ic.i_type || ic.load || ic.store;
                if (ic.beq || ic.bne || ic.blt) begin
                    if (branch_taken(ic, zero, neg)) begin
                        pc_we  = 1'b1;
                        pc_src = PC_BRANCH;
                    end
                    nxt = S_IF;
                end else if (ic.load || ic.store) begin
                    nxt = S_MEM;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                if (ic.load) begin
                    mem_rd = 1'b1;
                    if (mem_go) nxt = S_WB;
                end else begin
                    mem_wr = ic.store && mem_go;
                    if (mem_go) nxt = S_IF;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                wb_data = ic.load ? WB_MEM : WB_ALU;
                reg_des = ic.r_type;
                nxt     = S_IF;
            end
            S_HALT: nxt = S_HALT;
            default: nxt = S_IF;
        endcase
    end

    assign retire = (nxt == S_IF) && (cur inside {S_ID, S_EX, S_MEM, S_WB});
    assign state  = cur;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= S_IF;
            instret <= '0;
        end else begin
            cur <= nxt;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; expectations follow MCTRL_MEM_HANDSHAKE_EN when defined.
module tb_multicycle_ctrl;
    import mctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic [5:0]  opcode, opcode2;
    logic        zero, neg, mem_ready;
    logic [2:0]  state, state2;
    logic        pc_we, ir_we, reg_we, mem_rd, mem_wr;
    logic [1:0]  pc_src, wb_data;
    logic        alu_src, ext_src, reg_des, link, illegal;
    logic [15:0] instret;
    logic        pc_we2, ir_we2, reg_we2, mem_rd2, mem_wr2;
    logic [1:0]  pc_src2, wb_data2;
    logic        alu_src2, ext_src2, reg_des2, link2, illegal2;
    logic [1:0]  instret2;

    int vectors = 0;
    int miscompares = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .neg(neg),
        .mem_ready(mem_ready), .state(state), .pc_we(pc_we), .ir_we(ir_we),
        .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .pc_src(pc_src),
        .alu_src(alu_src), .ext_src(ext_src), .reg_des(reg_des), .link(link),
        .wb_data(wb_data), .illegal(illegal), .instret(instret)
    );

    multicycle_ctrl #(.CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset2), .opcode(opcode2), .zero(zero), .neg(neg),
        .mem_ready(mem_ready), .state(state2), .pc_we(pc_we2), .ir_we(ir_we2),
        .reg_we(reg_we2), .mem_rd(mem_rd2), .mem_wr(mem_wr2), .pc_src(pc_src2),
        .alu_src(alu_src2), .ext_src(ext_src2), .reg_des(reg_des2), .link(link2),
        .wb_data(wb_data2), .illegal(illegal2), .instret(instret2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Starts in IF; runs the branch through EX and back to IF.
    task automatic run_branch(input string tag, input logic [5:0] op, input logic z,
                              input logic n, input logic taken);
        opcode = op; zero = z; neg = n;
        tick();
        check({tag, "_id"}, state, S_ID);
        tick();
        check({tag, "_ex"}, state, S_EX);
        check({tag, "_pcwe"}, pc_we, taken);
        check({tag, "_pcsrc"}, pc_src, taken ? PC_BRANCH : PC_INC);
        tick();
        exp_ret++;
        check({tag, "_if"}, state, S_IF);
        check({tag, "_ret"}, instret, exp_ret);
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        opcode = OP_NOP; opcode2 = OP_NOP;
        zero = 1'b0; neg = 1'b0; mem_ready = 1'b0;
        repeat (2) tick();
        check("rst_state", state, S_IF);
        check("rst_instret", instret, 0);
        check("rst_illegal", illegal, 0);

        // R-type: IF, ID, EX, WB, IF
        opcode = OP_AND; mem_ready = 1'b1; reset = 1'b0;
        settle();
        check("add_if_state", state, S_IF);
        check("add_if_irwe", ir_we, 1);
        check("add_if_pcwe", pc_we, 1);
        check("add_if_memrd", mem_rd, 1);
        check("add_if_regwe", reg_we, 0);
        tick();
        check("add_id_state", state, S_ID);
        check("add_id_regwe", reg_we, 0);
        tick();
        check("add_ex_state", state, S_EX);
        check("add_ex_regwe", reg_we, 0);
        check("add_ex_alusrc", alu_src, 0);
        tick();
        check("add_wb_state", state, S_WB);
        check("add_wb_regwe", reg_we, 1);
        check("add_wb_regdes", reg_des, 1);
        check("add_wb_wbdata", wb_data, WB_ALU);
        check("add_wb_ret", instret, 0);
        tick();
        exp_ret++;
        check("add_if2_state", state, S_IF);
        check("add_if2_ret", instret, exp_ret);
        check("add_if2_regwe", reg_we, 0);

        // LW with mem_ready low for the first three MEM cycles
        opcode = OP_LW;
        tick();
        check("lw_id_state", state, S_ID);
        tick();
        check("lw_ex_state", state, S_EX);
        check("lw_ex_alusrc", alu_src, 1);
        check("lw_ex_extsrc", ext_src, 1);
        mem_ready = 1'b0;
        tick();
        check("lw_mem1_state", state, S_MEM);
        check("lw_mem1_memrd", mem_rd, 1);
`ifdef MCTRL_MEM_HANDSHAKE_EN
        for (int k = 0; k < 2; k++) begin
            tick();
            check("lw_memhold_state", state, S_MEM);
            check("lw_memhold_memrd", mem_rd, 1);
        end
        tick();
        mem_ready = 1'b1;
        settle();
        check("lw_mem4_state", state, S_MEM);
        check("lw_mem4_memrd", mem_rd, 1);
`endif
        tick();
        mem_ready = 1'b1;
        check("lw_wb_state", state, S_WB);
        check("lw_wb_wbdata", wb_data, WB_MEM);
        check("lw_wb_regwe", reg_we, 1);
        check("lw_wb_regdes", reg_des, 0);
        tick();
        exp_ret++;
        check("lw_if_ret", instret, exp_ret);

        run_branch("beq_t", OP_BEQ, 1'b1, 1'b0, 1'b1);
        run_branch("beq_n", OP_BEQ, 1'b0, 1'b0, 1'b0);
        run_branch("bne_t", OP_BNE, 1'b0, 1'b0, 1'b1);
        run_branch("blt_n", OP_BLT, 1'b1, 1'b0, 1'b0);
        zero = 1'b0;

        // CALL resolves in ID
        opcode = OP_CALL;
        tick();
        check("call_id_state", state, S_ID);
        check("call_pcwe", pc_we, 1);
        check("call_pcsrc", pc_src, PC_JUMP);
        check("call_regwe", reg_we, 1);
        check("call_link", link, 1);
        check("call_wbdata", wb_data, WB_PC1);
        tick();
        exp_ret++;
        check("call_if_state", state, S_IF);
        check("call_ret", instret, exp_ret);

        // Undefined opcode
        opcode = 6'b110000;
        settle();
        check("ill_if_illegal", illegal, 0);
        tick();
        check("ill_id_state", state, S_ID);
        check("ill_id_illegal", illegal, 1);
        tick();
        exp_ret++;
        check("ill_if_state", state, S_IF);
        check("ill_if_illegal2", illegal, 0);
        check("ill_ret", instret, exp_ret);

        // Store
        opcode = OP_SW;
        repeat (3) tick();
        check("sw_mem_state", state, S_MEM);
        check("sw_memwr", mem_wr, 1);
        check("sw_memrd", mem_rd, 0);
        tick();
        exp_ret++;
        check("sw_if_state", state, S_IF);
        check("sw_ret", instret, exp_ret);

        // Return
        opcode = OP_RET;
        tick();
        check("ret_pcwe", pc_we, 1);
        check("ret_pcsrc", pc_src, PC_RET);
        tick();
        exp_ret++;
        check("ret_if_ret", instret, exp_ret);

        // HALT holds until reset, not counted as retired
        opcode = OP_HALT;
        repeat (2) tick();
        check("halt_state", state, S_HALT);
        repeat (3) tick();
        check("halt_hold_state", state, S_HALT);
        check("halt_pcwe", pc_we, 0);
        check("halt_memrd", mem_rd, 0);
        check("halt_ret", instret, exp_ret);
        reset = 1'b1;
        settle();
        check("halt_rst_state", state, S_IF);
        check("halt_rst_ret", instret, 0);

        // 2-bit counter wrap, then async reset mid-EX
        reset2 = 1'b0; opcode2 = OP_NOP;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("w2_nop_id", state2, S_ID);
            tick();
            check("w2_nop_ret", instret2, (k + 1) % 4);
        end
        opcode2 = OP_AND;
        repeat (2) tick();
        check("w2_ex_state", state2, S_EX);
        reset2 = 1'b1;
        settle();
        check("w2_rst_state", state2, S_IF);
        check("w2_rst_ret", instret2, 0);
        tick();
        check("w2_rst_hold_ret", instret2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
